regwr_arbiter: RTL and testbench

REGWR_ARBITER -- requirements
Module: regwr_arbiter

---
 rtl/regwr_arbiter.sv | 91 +++++++++
 tb/tb_regwr_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/regwr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regwr_arbiter
// Purpose  : Round-robin arbiter merging ALU (A) and load (B) writebacks onto
//            one register-file write port, with a busy scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module regwr_arbiter #(
    parameter int n         = 16,
    parameter int reg_count = 8,
    parameter int addr_size = 3
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic                 A_Valid,
    input  logic [addr_size-1:0] A_Addr,
    input  logic [n-1:0]         A_Data,
    output logic                 A_Ready,
    input  logic                 B_Valid,
    input  logic [addr_size-1:0] B_Addr,
    input  logic [n-1:0]         B_Data,
    output logic                 B_Ready,
    input  logic                 Rsv,
    input  logic [addr_size-1:0] RsvAddr,
    output logic                 WE,
    output logic [addr_size-1:0] Rw,
    output logic [n-1:0]         WData,
    output logic [reg_count-1:0] Busy,
    output logic                 LastB
);

    logic                 w_grant_a;
    logic                 w_grant_b;
    logic                 w_xfer;
    logic [addr_size-1:0] w_addr;
    logic [n-1:0]         w_data;
    logic [reg_count-1:0] w_set;
    logic [reg_count-1:0] w_clr;

    logic                 r_we;
    logic [addr_size-1:0] r_rw;
    logic [n-1:0]         r_wdata;
    logic [reg_count-1:0] r_busy;
    logic                 r_lastb;

    // Ties go to whichever side did not win last; grants are masked in reset.
    always_comb begin
        w_grant_a = nReset & A_Valid & (~B_Valid | r_lastb);
        w_grant_b = nReset & B_Valid & (~A_Valid | ~r_lastb);
        w_xfer    = w_grant_a | w_grant_b;
        w_addr    = w_grant_b ? B_Addr : A_Addr;
        w_data    = w_grant_b ? B_Data : A_Data;
        w_set     = '0;
        w_clr     = '0;
        if (Rsv) begin
            w_set[RsvAddr] = 1'b1;
        end
        if (w_xfer) begin
            w_clr[w_addr] = 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_we    <= 1'b0;
            r_rw    <= '0;
            r_wdata <= '0;
            r_busy  <= '0;
            r_lastb <= 1'b0;
        end else begin
            r_we <= w_xfer;
            if (w_xfer) begin
                r_rw    <= w_addr;
                r_wdata <= w_data;
                r_lastb <= w_grant_b;
            end
            // Set applied after clear so a same-edge reservation survives.
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    assign A_Ready = w_grant_a;
    assign B_Ready = w_grant_b;
    assign WE      = r_we;
    assign Rw      = r_rw;
    assign WData   = r_wdata;
    assign Busy    = r_busy;
    assign LastB   = r_lastb;

endmodule
`default_nettype wire

// File: tb/tb_regwr_arbiter.sv
`default_nettype none
// Testbench for regwr_arbiter: directed steps, scoreboard of expected writes.
module tb_regwr_arbiter;

    logic        Clock = 1'b0;
    logic        nReset;
    logic        A_Valid, B_Valid, Rsv;
    logic [2:0]  A_Addr, B_Addr, RsvAddr;
    logic [15:0] A_Data, B_Data;
    logic        A_Ready, B_Ready, WE, LastB;
    logic [2:0]  Rw;
    logic [15:0] WData;
    logic [7:0]  Busy;

    int checks   = 0;
    int failures = 0;

    logic [18:0] sb[$];
    logic        m_lastb;
    logic [7:0]  m_busy;
    logic [2:0]  m_rw;
    logic [15:0] m_wd;
    logic        last_ga, last_gb;
    logic [15:0] rf [8] = '{default: 16'h0000};

    regwr_arbiter #(.n(16), .reg_count(8), .addr_size(3)) dut (
        .Clock(Clock), .nReset(nReset),
        .A_Valid(A_Valid), .A_Addr(A_Addr), .A_Data(A_Data), .A_Ready(A_Ready),
        .B_Valid(B_Valid), .B_Addr(B_Addr), .B_Data(B_Data), .B_Ready(B_Ready),
        .Rsv(Rsv), .RsvAddr(RsvAddr),
        .WE(WE), .Rw(Rw), .WData(WData), .Busy(Busy), .LastB(LastB)
    );

    always #5 Clock = ~Clock;

    // Register file fed by the DUT write port
    always @(posedge Clock) begin
        if (WE === 1'b1) rf[Rw] <= WData;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check Ready at negedge, predict, then check outputs after the edge.
    task automatic cycle();
        logic        ea, eb;
        logic [7:0]  set_m, clr_m;
        logic [18:0] e;
        @(negedge Clock);
        ea = A_Valid & (~B_Valid | m_lastb);
        eb = B_Valid & (~A_Valid | ~m_lastb);
        chk("A_Ready", {31'b0, A_Ready}, {31'b0, ea});
        chk("B_Ready", {31'b0, B_Ready}, {31'b0, eb});
        set_m = Rsv ? (8'h01 << RsvAddr) : 8'h00;
        clr_m = 8'h00;
        if (eb) begin
            sb.push_back({B_Addr, B_Data});
            clr_m   = 8'h01 << B_Addr;
            m_lastb = 1'b1;
        end else if (ea) begin
            sb.push_back({A_Addr, A_Data});
            clr_m   = 8'h01 << A_Addr;
            m_lastb = 1'b0;
        end
        m_busy  = (m_busy & ~clr_m) | set_m;
        last_ga = ea;
        last_gb = eb;
        @(posedge Clock);
        #1;
        if (sb.size() > 0) begin
            e    = sb.pop_front();
            m_rw = e[18:16];
            m_wd = e[15:0];
            chk("WE_write", {31'b0, WE}, 32'd1);
        end else begin
            chk("WE_idle", {31'b0, WE}, 32'd0);
        end
        chk("Rw", {29'b0, Rw}, {29'b0, m_rw});
        chk("WData", {16'b0, WData}, {16'b0, m_wd});
        chk("Busy", {24'b0, Busy}, {24'b0, m_busy});
        chk("LastB", {31'b0, LastB}, {31'b0, m_lastb});
    endtask

    initial begin
        logic [3:0] order;
        nReset = 1'b0;
        A_Valid = 0; B_Valid = 0; Rsv = 0;
        A_Addr = 0; B_Addr = 0; RsvAddr = 0;
        A_Data = 0; B_Data = 0;
        m_lastb = 0; m_busy = 0; m_rw = 0; m_wd = 0;
        last_ga = 0; last_gb = 0;

        // Reset state
        #12;
        chk("rst_WE", {31'b0, WE}, 32'd0);
        chk("rst_Rw", {29'b0, Rw}, 32'd0);
        chk("rst_WData", {16'b0, WData}, 32'd0);
        chk("rst_Busy", {24'b0, Busy}, 32'd0);
        chk("rst_LastB", {31'b0, LastB}, 32'd0);
        @(posedge Clock); #1;
        nReset = 1'b1;

        // Single A write, then idle with held address/data
        A_Valid = 1; A_Addr = 3; A_Data = 16'h1234;
        cycle();
        chk("single_Rw", {29'b0, Rw}, 32'd3);
        chk("single_WData", {16'b0, WData}, 32'h1234);
        A_Valid = 0;
        cycle();

        // Four-cycle tie with fresh data after each grant: B,A,B,A
        order = 4'b0101;
        A_Valid = 1; A_Addr = 1; A_Data = 16'hAAAA;
        B_Valid = 1; B_Addr = 2; B_Data = 16'hBBBB;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("tie_grant_b", {31'b0, last_gb}, {31'b0, order[i]});
            if (last_gb) B_Data = B_Data + 16'h1;
            else         A_Data = A_Data + 16'h1;
        end
        A_Valid = 0; B_Valid = 0;
        cycle();

        // Reserve reg 5, then B writes it
        Rsv = 1; RsvAddr = 5;
        cycle();
        chk("rsv5_Busy", {24'b0, Busy}, 32'h20);
        Rsv = 0; B_Valid = 1; B_Addr = 5; B_Data = 16'h5555;
        cycle();
        chk("clr5_Busy", {24'b0, Busy}, 32'h00);
        B_Valid = 0;

        // Reservation and write to reg 4 on the same edge
        Rsv = 1; RsvAddr = 4;
        cycle();
        A_Valid = 1; A_Addr = 4; A_Data = 16'h4444;
        cycle();
        chk("collide_Busy", {24'b0, Busy}, 32'h10);
        Rsv = 0; A_Addr = 0; A_Data = 16'h0F0F;
        cycle();
        A_Addr = 4; A_Data = 16'h4445;
        cycle();
        chk("free_Busy", {24'b0, Busy}, 32'h00);
        A_Valid = 0;

        // Same-address tie on reg 7: B first, A last
        A_Valid = 1; A_Addr = 7; A_Data = 16'h0001;
        B_Valid = 1; B_Addr = 7; B_Data = 16'h0002;
        cycle();
        chk("same_first_b", {31'b0, last_gb}, 32'd1);
        B_Valid = 0;
        cycle();
        chk("same_second_a", {31'b0, last_ga}, 32'd1);
        A_Valid = 0;
        cycle();
        chk("reg7_final", {16'b0, rf[7]}, 32'h0001);

        // Reset while a write to reg 6 is on the port
        B_Valid = 1; B_Addr = 6; B_Data = 16'h6666; Rsv = 1; RsvAddr = 3;
        cycle();
        B_Valid = 0; Rsv = 0;
        #2;
        nReset = 1'b0;
        #1;
        chk("midrst_WE", {31'b0, WE}, 32'd0);
        chk("midrst_Busy", {24'b0, Busy}, 32'd0);
        chk("midrst_LastB", {31'b0, LastB}, 32'd0);
        A_Valid = 1; Rsv = 1; RsvAddr = 2;
        #1;
        chk("midrst_A_Ready", {31'b0, A_Ready}, 32'd0);
        @(posedge Clock); #1;
        chk("inrst_Busy", {24'b0, Busy}, 32'd0);
        chk("inrst_WE", {31'b0, WE}, 32'd0);
        A_Valid = 0; Rsv = 0;
        sb.delete();
        m_lastb = 0; m_busy = 0; m_rw = 0; m_wd = 0;
        nReset = 1'b1;
        cycle();
        chk("reg6_untouched", {16'b0, rf[6]}, 32'h0000);

        // First tie after reset goes to B
        A_Valid = 1; A_Addr = 1; A_Data = 16'hC001;
        B_Valid = 1; B_Addr = 2; B_Data = 16'hC002;
        cycle();
        chk("post_rst_tie_b", {31'b0, last_gb}, 32'd1);
        B_Valid = 0;
        cycle();
        A_Valid = 0;
        cycle();
        chk("reg6_final", {16'b0, rf[6]}, 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
